// File: rtl/vtdl_fifo_pkg.sv
// Shared definitions for vtdl-based FIFO wrappers: sizing helpers and
// the status-flag bundle.
package vtdl_fifo_pkg;

    // Default geometry for wrappers that do not override it.
    localparam int DEF_WID = 8;
    localparam int DEF_DEP = 16;

    // Address width needed to select one of dep storage entries.
    function automatic int fifo_aw(input int dep);
        return $clog2(dep);
    endfunction

    // Occupancy width: must represent 0..dep inclusive.
    function automatic int fifo_cntw(input int dep);
        return $clog2(dep) + 1;
    endfunction

    localparam int AW   = fifo_aw(DEF_DEP);
    localparam int CNTW = fifo_cntw(DEF_DEP);

    // Status flags shared by peer FIFO wrappers.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic ovf;
        logic unf;
    } fifo_status_t;

endpackage

// File: rtl/vtdl.sv
// Variable tap delay line: a shift register of DEP words with a
// combinational read tap selected by a.
module vtdl
    import vtdl_fifo_pkg::*;
#(
    parameter int WID = 8,
    parameter int DEP = 16
) (
    input  logic                    clk,
    input  logic                    ce,
    input  logic [WID-1:0]          d,
    input  logic [fifo_aw(DEP)-1:0] a,
    output logic [WID-1:0]          q
);

    logic [WID-1:0] r_sr [DEP];

    // Shift a new word into entry 0 on every enabled edge; older words move up.
    // NOTE: the storage array has no reset -- its contents are only ever
    // read through a tap the controller knows is valid, and leaving it
    // unreset lets it map onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_sr[0] <= d;
            for (int i = 1; i < DEP; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign q = r_sr[a];

endmodule

// File: rtl/vtdl_fifo.sv
// First-word-fall-through FIFO controller around a vtdl. Newest word
// sits at entry 0; ptr tracks the oldest entry (count-1) so the read tap
// needs no subtractor.
module vtdl_fifo
    import vtdl_fifo_pkg::*;
#(
    parameter int WID    = 8,
    parameter int DEP    = 16,
    parameter int AFULL  = DEP - 2,
    parameter int AEMPTY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr,
    input  logic [WID-1:0]       din,
    input  logic                 rd,
    output logic [WID-1:0]       dout,
    output logic                 empty,
    output logic                 full,
    output logic [$clog2(DEP):0] count,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 ovf,
    output logic                 unf
);

    localparam int L_AW   = fifo_aw(DEP);
    localparam int L_CNTW = fifo_cntw(DEP);

    localparam logic [L_CNTW-1:0] DEP_C    = L_CNTW'(DEP);
    localparam logic [L_CNTW-1:0] AFULL_C  = L_CNTW'(AFULL);
    localparam logic [L_CNTW-1:0] AEMPTY_C = L_CNTW'(AEMPTY);
    localparam logic [L_CNTW-1:0] ONE_C    = L_CNTW'(1);
    localparam logic [L_AW-1:0]   PTR_ONE  = L_AW'(1);

    // Reset image of the status flags: empty, and hence almost-empty too.
    localparam fifo_status_t ST_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        ovf:          1'b0,
        unf:          1'b0
    };

    logic [L_CNTW-1:0] r_count;
    logic [L_AW-1:0]   r_ptr;
    fifo_status_t      r_st;

    logic [L_CNTW-1:0] w_cnt_nxt;
    logic [L_AW-1:0]   w_ptr_nxt;
    fifo_status_t      w_st_nxt;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ce;

    // A read is only honoured when data is held; a write into a full FIFO
    // is honoured only if a read frees the oldest slot in the same cycle.
    assign w_rd_acc = rd & ~r_st.empty;
    assign w_wr_acc = wr & (~r_st.full | w_rd_acc);

    // Flush suppresses the shift, and no shift may leak out while the
    // controller is held in reset.
    assign w_ce = w_wr_acc & ~clr & rst_n;

    vtdl #(
        .WID (WID),
        .DEP (DEP)
    ) u_vtdl (
        .clk (clk),
        .ce  (w_ce),
        .d   (din),
        .a   (r_ptr),
        .q   (dout)
    );

    // Next occupancy and oldest-entry pointer.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_cnt_nxt = r_count;
        w_ptr_nxt = r_ptr;
        if (clr) begin
            w_cnt_nxt = '0;
            w_ptr_nxt = '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10: begin
                    w_cnt_nxt = r_count + ONE_C;
                    w_ptr_nxt = (r_count == '0) ? '0 : r_ptr + PTR_ONE;
                end
                2'b01: begin
                    w_cnt_nxt = r_count - ONE_C;
                    w_ptr_nxt = (r_count == ONE_C) ? '0 : r_ptr - PTR_ONE;
                end
                default: begin
                    // Simultaneous push/pop shifts the oldest word past ptr,
                    // so occupancy and pointer both hold.
                end
            endcase
        end
    end

    // Status flags derived from the next count so they move with count;
    // sticky error bits accumulate until a flush, which takes priority.
    always_comb begin
        w_st_nxt              = r_st;
        w_st_nxt.empty        = (w_cnt_nxt == '0);
        w_st_nxt.full         = (w_cnt_nxt == DEP_C);
        w_st_nxt.almost_empty = (w_cnt_nxt <= AEMPTY_C);
        w_st_nxt.almost_full  = (w_cnt_nxt >= AFULL_C);
        w_st_nxt.ovf          = ~clr & (r_st.ovf | (wr & ~w_wr_acc));
        w_st_nxt.unf          = ~clr & (r_st.unf | (rd & r_st.empty));
    end

    // Control state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ptr   <= '0;
            r_st    <= ST_RESET;
        end else begin
            r_count <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_st    <= w_st_nxt;
        end
    end

    assign count        = r_count;
    assign empty        = r_st.empty;
    assign full         = r_st.full;
    assign almost_empty = r_st.almost_empty;
    assign almost_full  = r_st.almost_full;
    assign ovf          = r_st.ovf;
    assign unf          = r_st.unf;

endmodule

// File: doc/vtdl_fifo.md
Name: vtdl_fifo

Overview:
- Synchronous first-word-fall-through FIFO.
- Storage is one vtdl (variable tap delay line) instance; this block is the controller that sequences it.
  - Drives the shift enable on every accepted write.
  - Steers the tap address to the oldest entry.
- Also tracks occupancy and produces status and error flags.
- Intended for rate matching in the UART receive/transmit paths and similar small buffers.

Parameters:
- WID, 8, data width in bits.
- DEP, 16, storage depth; must be a power of two, at least 2.
- AFULL, DEP-2, almost_full asserts when count >= AFULL.
- AEMPTY, 1, almost_empty asserts when count <= AEMPTY.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO and clears the sticky flags.
- wr  input  1  write request.
- din  input  WID  write data.
- rd  input  1  read/pop request (FWFT: dout is already valid while empty=0).
- dout  output  WID  oldest entry.
- empty  output  1  no entries held.
- full  output  1  DEP entries held.
- count  output  $clog2(DEP)+1  current occupancy, 0..DEP.
- almost_full  output  1  count >= AFULL.
- almost_empty  output  1  count <= AEMPTY.
- ovf  output  1  sticky: a write was rejected.
- unf  output  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, ptr=0, empty=1, full=0, almost_empty=1, almost_full=0, ovf=0, unf=0.
  - Storage contents are not reset.
- Storage mapping:
  - vtdl entry 0 holds the newest word.
  - The oldest word is at entry count-1.
  - Internal register ptr holds count-1 (0 when empty) and drives the vtdl address directly; no subtractor in the read path.
  - dout = vtdl q, combinational from ptr.
- Accept conditions:
  - wr_acc = wr & (~full | rd_acc).
  - rd_acc = rd & ~empty.
  - vtdl ce = wr_acc; din feeds vtdl d.
- Count/ptr update at the clock edge:
  - wr_acc only: count+1; ptr+1, except when count was 0, in which case ptr stays 0.
  - rd_acc only: count-1; ptr-1, except when the new count is 0, in which case ptr stays 0.
  - Both: shift occurs, the oldest word moves past ptr, count and ptr are unchanged.
  - Neither: hold.
- Flags:
  - empty, full, almost_empty and almost_full are registered, computed from the next count; they change in the same cycle as count.
  - Write-to-read latency is 1 cycle: after a write into an empty FIFO, empty=0 and dout=din on the next cycle.
- Full boundary:
  - wr with full=1 and rd=0 is rejected; ovf is set.
  - wr with full=1 and rd_acc=1 is accepted: entry DEP-1 is popped as it shifts out, count stays DEP.
- Empty boundary:
  - rd with empty=1 is rejected and unf is set. If wr is also asserted, the write is still accepted; there is no bypass to dout.
  - dout is don't-care while empty (ptr=0 presents entry 0).
- clr:
  - Forces count=0, ptr=0, empty=1, full=0 and clears ovf/unf on the next edge.
  - Overrides wr/rd in the same cycle; no shift occurs.
- Sticky flags:
  - ovf and unf hold until clr or reset.
  - Setting and clearing in the same cycle: clr wins.
- Reset mid-operation: asynchronous return to the reset state. Partially filled contents are abandoned, with no spurious ce.

Decomposition:
- Shared package holds:
  - occupancy width function/constant CNTW = $clog2(DEP)+1 and address width AW = $clog2(DEP);
  - a fifo_status_t packed struct {empty, full, almost_empty, almost_full, ovf, unf} for reuse by peer FIFO wrappers.
- One sub-module: the existing vtdl instance (WID, DEP passed through) as storage.
- All control (ptr, count, flags) stays in vtdl_fifo.

Test Plan:
- Reset then write 0x11,0x22,0x33, no reads:
  - empty drops 1 cycle after the first write; count=3; dout=0x11.
  - Three rd pulses yield 0x11, 0x22, 0x33, then empty=1, count=0.
- Fill to 16 with 0x00..0x0F:
  - full=1 and almost_full=1 from count 14.
  - Extra wr of 0xAA is rejected; ovf=1; count=16; dout=0x00.
- While full, assert wr=0xBB and rd together:
  - count stays 16; dout becomes 0x01.
  - After draining, 0xBB is the last word out.
- From empty:
  - rd alone sets unf=1.
  - rd+wr of 0x5A: count=1, unf stays 1, dout=0x5A next cycle.
- Load 5 words, pulse clr alongside wr:
  - count=0, empty=1, ovf/unf=0, no shift occurs.
- Mid-fill with count=7, pulse rst_n low asynchronously between edges:
  - outputs reach reset values immediately.
  - A subsequent write of 0x77 reads back as 0x77.
